// File: rtl/ex_cond_flag_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_cond_flag_stage
// Description : EX/MEM stage holding N/Z/C/V flags, condition check, branch flag
// Revision    : 1.0
// ============================================================================
module ex_cond_flag_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              n_in,
    input  logic              z_in,
    input  logic              c_in,
    input  logic              o_in,
    input  logic              set_flags,
    input  logic [3:0]        cond,
    input  logic              is_branch,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              reg_write_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_res,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_write,
    output logic              branch_taken,
    output logic [3:0]        flags_q
);

    localparam logic [3:0] c_EQ = 4'd0;
    localparam logic [3:0] c_NE = 4'd1;
    localparam logic [3:0] c_CS = 4'd2;
    localparam logic [3:0] c_CC = 4'd3;
    localparam logic [3:0] c_MI = 4'd4;
    localparam logic [3:0] c_PL = 4'd5;
    localparam logic [3:0] c_VS = 4'd6;
    localparam logic [3:0] c_VC = 4'd7;
    localparam logic [3:0] c_HI = 4'd8;
    localparam logic [3:0] c_LS = 4'd9;
    localparam logic [3:0] c_GE = 4'd10;
    localparam logic [3:0] c_LT = 4'd11;
    localparam logic [3:0] c_GT = 4'd12;
    localparam logic [3:0] c_LE = 4'd13;
    localparam logic [3:0] c_AL = 4'd14;

    logic              r_valid;
    logic [DATA_W-1:0] r_res;
    logic [RD_W-1:0]   r_rd;
    logic              r_reg_write;
    logic              r_branch;
    logic [3:0]        r_flags;

    logic w_n, w_z, w_c, w_v;
    logic w_pass;
    logic w_exec;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Condition uses the flags before this instruction, so a flag-setter
    // followed directly by a conditional sees the new flags without forwarding.
    always_comb begin
        w_pass = 1'b0;
        case (cond)
            c_EQ:    w_pass = w_z;
            c_NE:    w_pass = ~w_z;
            c_CS:    w_pass = w_c;
            c_CC:    w_pass = ~w_c;
            c_MI:    w_pass = w_n;
            c_PL:    w_pass = ~w_n;
            c_VS:    w_pass = w_v;
            c_VC:    w_pass = ~w_v;
            c_HI:    w_pass = w_c & ~w_z;
            c_LS:    w_pass = ~w_c | w_z;
            c_GE:    w_pass = (w_n == w_v);
            c_LT:    w_pass = (w_n != w_v);
            c_GT:    w_pass = ~w_z & (w_n == w_v);
            c_LE:    w_pass = w_z | (w_n != w_v);
            c_AL:    w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    assign w_exec = in_valid & w_pass & ~flush & ~stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_res       <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_branch    <= 1'b0;
            r_flags     <= 4'b0000;
        end else if (flush) begin
            // Squash only the control bits; data and flags hold.
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_branch    <= 1'b0;
        end else if (!stall) begin
            r_valid     <= w_exec;
            r_res       <= alu_res;
            r_rd        <= rd_in;
            r_reg_write <= w_exec & reg_write_in;
            r_branch    <= w_exec & is_branch;
            if (w_exec && set_flags) begin
                r_flags <= {n_in, z_in, c_in, o_in};
            end
        end
    end

    assign out_valid     = r_valid;
    assign out_res       = r_res;
    assign out_rd        = r_rd;
    assign out_reg_write = r_reg_write;
    assign branch_taken  = r_branch;
    assign flags_q       = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_ex_cond_flag_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_cond_flag_stage
// Description : Scoreboard bench for ex_cond_flag_stage with directed vectors
// Revision    : 1.0
// ============================================================================
module tb_ex_cond_flag_stage;

    localparam int DATA_W = 32;
    localparam int RD_W   = 3;

    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] res;
        logic [RD_W-1:0]   rd;
        logic              rw;
        logic              br;
        logic [3:0]        flags;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall, flush, in_valid;
    logic [DATA_W-1:0] alu_res;
    logic              n_in, z_in, c_in, o_in;
    logic              set_flags;
    logic [3:0]        cond;
    logic              is_branch;
    logic [RD_W-1:0]   rd_in;
    logic              reg_write_in;
    logic              out_valid;
    logic [DATA_W-1:0] out_res;
    logic [RD_W-1:0]   out_rd;
    logic              out_reg_write;
    logic              branch_taken;
    logic [3:0]        flags_q;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    ex_cond_flag_stage #(.DATA_W(DATA_W), .RD_W(RD_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .alu_res      (alu_res),
        .n_in         (n_in),
        .z_in         (z_in),
        .c_in         (c_in),
        .o_in         (o_in),
        .set_flags    (set_flags),
        .cond         (cond),
        .is_branch    (is_branch),
        .rd_in        (rd_in),
        .reg_write_in (reg_write_in),
        .out_valid    (out_valid),
        .out_res      (out_res),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write),
        .branch_taken (branch_taken),
        .flags_q      (flags_q)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a.v     = out_valid;
        a.res   = out_res;
        a.rd    = out_rd;
        a.rw    = out_reg_write;
        a.br    = branch_taken;
        a.flags = flags_q;
        return a;
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = actual();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got v=%0b res=%h rd=%0d rw=%0b br=%0b flags=%b, expected v=%0b res=%h rd=%0d rw=%0b br=%0b flags=%b",
                     name, a.v, a.res, a.rd, a.rw, a.br, a.flags,
                     e.v, e.res, e.rd, e.rw, e.br, e.flags);
        end
    endtask

    // Monitor: each edge that has a pending expectation is checked shortly after.
    initial begin
        exp_t e;
        int   n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n++;
                compare($sformatf("vec%0d", n), e);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic issue(input logic st, input logic fl, input logic iv,
                         input logic [DATA_W-1:0] res, input logic [3:0] nzcv,
                         input logic sf, input logic [3:0] cd, input logic br,
                         input logic [RD_W-1:0] rd, input logic rw,
                         input logic ev, input logic [DATA_W-1:0] eres,
                         input logic [RD_W-1:0] erd, input logic erw,
                         input logic ebr, input logic [3:0] eflags);
        exp_t e;
        @(negedge clk);
        stall        = st;
        flush        = fl;
        in_valid     = iv;
        alu_res      = res;
        {n_in, z_in, c_in, o_in} = nzcv;
        set_flags    = sf;
        cond         = cd;
        is_branch    = br;
        rd_in        = rd;
        reg_write_in = rw;
        e.v = ev; e.res = eres; e.rd = erd; e.rw = erw; e.br = ebr; e.flags = eflags;
        sb_q.push_back(e);
    endtask

    initial begin
        exp_t zero;
        int   wait_cnt;
        zero = '0;
        reset = 1'b1;
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_res = '0;
        n_in = 1'b0; z_in = 1'b0; c_in = 1'b0; o_in = 1'b0;
        set_flags = 1'b0; cond = 4'd0; is_branch = 1'b0; rd_in = '0; reg_write_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        compare("reset_state", zero);
        @(negedge clk);
        reset = 1'b0;

        //    st fl iv res      nzcv     sf cond br rd rw   ev eres     erd rw br flags
        issue(0, 0, 1, 32'h11, 4'b0100, 1, 4'd14, 0, 1, 0,  1, 32'h11, 1, 0, 0, 4'b0100); // set Z
        issue(0, 0, 1, 32'h05, 4'b0000, 0, 4'd0,  0, 3, 1,  1, 32'h05, 3, 1, 0, 4'b0100); // EQ pass
        issue(0, 0, 1, 32'h22, 4'b1000, 1, 4'd1,  1, 2, 1,  0, 32'h22, 2, 0, 0, 4'b0100); // NE fail
        issue(0, 0, 1, 32'h30, 4'b1000, 1, 4'd14, 0, 4, 1,  1, 32'h30, 4, 1, 0, 4'b1000); // N=1 V=0
        issue(0, 0, 1, 32'h31, 4'b0000, 0, 4'd11, 0, 5, 1,  1, 32'h31, 5, 1, 0, 4'b1000); // LT pass
        issue(0, 0, 1, 32'h32, 4'b0000, 0, 4'd10, 0, 6, 1,  0, 32'h32, 6, 0, 0, 4'b1000); // GE fail
        issue(0, 0, 1, 32'h40, 4'b1100, 1, 4'd14, 0, 1, 0,  1, 32'h40, 1, 0, 0, 4'b1100); // add Z
        issue(0, 0, 1, 32'h41, 4'b0000, 0, 4'd12, 0, 2, 1,  0, 32'h41, 2, 0, 0, 4'b1100); // GT fail
        issue(0, 0, 1, 32'h42, 4'b0000, 0, 4'd13, 0, 3, 1,  1, 32'h42, 3, 1, 0, 4'b1100); // LE pass
        issue(1, 0, 1, 32'h50, 4'b0011, 1, 4'd14, 1, 7, 1,  1, 32'h42, 3, 1, 0, 4'b1100); // stall
        issue(1, 0, 0, 32'h51, 4'b1111, 1, 4'd14, 1, 6, 0,  1, 32'h42, 3, 1, 0, 4'b1100); // stall
        issue(1, 0, 1, 32'h52, 4'b0001, 1, 4'd0,  0, 5, 1,  1, 32'h42, 3, 1, 0, 4'b1100); // stall
        issue(0, 0, 1, 32'h55, 4'b0011, 1, 4'd14, 1, 7, 1,  1, 32'h55, 7, 1, 1, 4'b0011); // release
        issue(1, 1, 1, 32'h66, 4'b1111, 1, 4'd14, 1, 4, 1,  0, 32'h55, 7, 0, 0, 4'b0011); // flush+stall
        issue(0, 0, 1, 32'h77, 4'b0000, 0, 4'd14, 1, 1, 0,  1, 32'h77, 1, 0, 1, 4'b0011); // taken branch
        issue(0, 0, 0, 32'h88, 4'b1111, 1, 4'd14, 1, 2, 1,  0, 32'h88, 2, 0, 0, 4'b0011); // in_valid=0
        issue(0, 1, 1, 32'h99, 4'b1111, 1, 4'd14, 0, 5, 1,  0, 32'h88, 2, 0, 0, 4'b0011); // flush only
        issue(0, 0, 1, 32'hA0, 4'b0000, 0, 4'd8,  0, 3, 1,  1, 32'hA0, 3, 1, 0, 4'b0011); // HI pass
        issue(0, 0, 1, 32'hA1, 4'b0000, 0, 4'd6,  0, 4, 1,  1, 32'hA1, 4, 1, 0, 4'b0011); // VS pass
        issue(0, 0, 1, 32'hA2, 4'b0000, 0, 4'd4,  0, 5, 1,  0, 32'hA2, 5, 0, 0, 4'b0011); // MI fail
        issue(0, 0, 1, 32'hA3, 4'b0000, 0, 4'd15, 1, 6, 1,  0, 32'hA3, 6, 0, 0, 4'b0011); // NV fail
        issue(0, 0, 1, 32'hA4, 4'b0000, 0, 4'd5,  0, 7, 1,  1, 32'hA4, 7, 1, 0, 4'b0011); // PL pass
        issue(0, 0, 1, 32'hA5, 4'b0000, 0, 4'd3,  0, 1, 1,  0, 32'hA5, 1, 0, 0, 4'b0011); // CC fail
        issue(0, 0, 1, 32'hA6, 4'b0000, 0, 4'd9,  0, 2, 1,  0, 32'hA6, 2, 0, 0, 4'b0011); // LS fail
        issue(0, 0, 1, 32'hA7, 4'b0000, 0, 4'd7,  0, 3, 1,  0, 32'hA7, 3, 0, 0, 4'b0011); // VC fail
        issue(0, 0, 1, 32'hA8, 4'b0000, 0, 4'd2,  0, 4, 1,  1, 32'hA8, 4, 1, 0, 4'b0011); // CS pass
        issue(0, 0, 1, 32'hB0, 4'b1111, 1, 4'd14, 0, 6, 1,  1, 32'hB0, 6, 1, 0, 4'b1111); // flags=1111

        // Asynchronous reset mid-cycle while out_valid=1 and flags_q=1111.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        compare("async_reset", zero);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_cond_flag_stage.md
Name: ex_cond_flag_stage

Overview:
- Execute-to-memory stage directly downstream of the ALU.
- Holds the architectural N/Z/C/V status flags and evaluates a 4-bit condition code against them.
- Registers the ALU result plus destination/write-enable into an EX/MEM pipeline register, and produces a registered branch-taken indication.
- Supports a stall (hold) handshake and a flush (squash) handshake from the hazard logic.

Parameters:
- DATA_W, 32, ALU result width.
- RD_W, 3, destination register address width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  hold all stage state this cycle
- flush  input  1  squash the instruction entering this cycle
- in_valid  input  1  ALU output carries a real instruction
- alu_res  input  DATA_W  ALU result
- n_in, z_in, c_in, o_in  input  1 each  ALU flags for this instruction
- set_flags  input  1  instruction updates status flags
- cond  input  4  condition code of the instruction
- is_branch  input  1  instruction is a branch
- rd_in  input  RD_W  destination register
- reg_write_in  input  1  instruction writes rd_in
- out_valid  output  1  EX/MEM holds an executed instruction
- out_res  output  DATA_W  registered result
- out_rd  output  RD_W  registered destination
- out_reg_write  output  1  registered write enable
- branch_taken  output  1  registered: executed branch in EX/MEM
- flags_q  output  4  architectural flags {N,Z,C,V}

Behaviour:
- Reset is asynchronous, active-high. While reset is high, every output and flags_q is 0. Reset asserted mid-operation discards the in-flight instruction and the flags.
- Condition evaluation is combinational on flags_q (the flags before this instruction), giving pass:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z & (N==V)
  - 13 LE: Z | (N!=V)
  - 14 AL: 1
  - 15 NV: 0
- exec = in_valid & pass & !flush & !stall.
- On each rising clk edge, priority is reset > flush > stall > normal.
- Flush (regardless of stall):
  - out_valid, out_reg_write and branch_taken become 0.
  - out_res and out_rd hold.
  - flags_q is not updated.
- Stall (no flush): all registers, including flags_q, hold.
- Normal:
  - out_valid <= exec.
  - out_res <= alu_res and out_rd <= rd_in (captured every normal cycle, don't-care when out_valid=0).
  - out_reg_write <= exec & reg_write_in.
  - branch_taken <= exec & is_branch.
  - If exec & set_flags: flags_q <= {n_in, z_in, c_in, o_in}.
- Latency: one cycle from inputs to outputs. Flags written at edge k are visible to the condition of the instruction presented in cycle k+1, so back-to-back flag-set then conditional instructions need no forwarding.
- Condition-failed instruction (in_valid=1, pass=0): becomes a bubble (out_valid=0). Its flags, write and branch are suppressed.
- in_valid=0: bubble; flags untouched regardless of set_flags.
- Width rule: flags are stored exactly as produced by the ALU; no recomputation in this stage.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with out_valid=1 and flags_q=4'b1111 -> all outputs and flags_q go to 0 immediately, without a clock edge.
- Flag set then conditional: cycle 1 presents set_flags=1, z_in=1, cond=AL. Cycle 2 presents cond=EQ, reg_write_in=1, rd_in=3, alu_res=32'h5 -> after cycle 2 edge: out_valid=1, out_reg_write=1, out_rd=3, out_res=5, flags_q=4'b0100.
- Condition fail: flags_q=4'b0100, cond=NE, is_branch=1, set_flags=1, n_in=1 -> out_valid=0, branch_taken=0, flags_q stays 4'b0100.
- Signed compare: flags_q N=1,V=0; cond=LT -> executes; cond=GE -> bubble. With Z=1, cond=GT -> bubble and cond=LE -> executes.
- Stall: stall held 3 cycles with changing inputs -> all outputs and flags_q constant. On release, the instruction present then is captured on the next edge.
- Flush beats stall: stall=1, flush=1, executable branch with set_flags=1 -> out_valid=0, branch_taken=0, flags_q unchanged. A taken branch (cond=AL, is_branch=1) in the next normal cycle gives branch_taken=1 for exactly one cycle.
